// File: rtl/demux_pkg.sv
// Shared constants and types for the buffered 1-to-4 demultiplexer.
package demux_pkg;

  localparam int unsigned DEFAULT_WIDTH = 3;
  localparam int unsigned NUM_CH        = 4;

  typedef logic [1:0] ch_idx_t;

endpackage

// File: rtl/demux_1x4_buffered_channel.sv
// One output channel: holding register plus a full flag, loaded by the top
// level and released by the consumer's ack.
module demux_channel
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             ack,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] y,
  output logic             full
);

  // load is only raised while the channel is empty, so load taking priority
  // over ack never loses an outstanding word; ack on an empty channel is a no-op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y    <= '0;
      full <= 1'b0;
    end else if (load) begin
      y    <= din;
      full <= 1'b1;
    end else if (ack) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1x4_buffered.sv
// Buffered 1-to-4 demultiplexer: routes din to an explicit or round-robin
// target channel, flagging words dropped on a full target with overrun.
module demux_1x4_buffered
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              auto_mode,
  input  logic              s1,
  input  logic              s0,
  output logic [WIDTH-1:0]  y0,
  output logic [WIDTH-1:0]  y1,
  output logic [WIDTH-1:0]  y2,
  output logic [WIDTH-1:0]  y3,
  output logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] ack,
  output logic              overrun,
  output logic [1:0]        ptr
);

  ch_idx_t             target;
  ch_idx_t             ptr_q;
  logic                accept;
  logic                overrun_q;
  logic [NUM_CH-1:0]   load;
  logic [NUM_CH-1:0]   full_q;
  logic [WIDTH-1:0]    y_q [NUM_CH];

  always_comb begin
    target    = auto_mode ? ptr_q : ch_idx_t'({s1, s0});
    din_ready = ~full_q[target];
    accept    = din_valid & din_ready;
    load      = '0;
    if (accept) load[target] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= din_valid & ~din_ready;
      if (accept && auto_mode) ptr_q <= ptr_q + 2'd1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    demux_channel #(.WIDTH(WIDTH)) u_ch (
      .clk  (clk),
      .rst  (rst),
      .load (load[i]),
      .ack  (ack[i]),
      .din  (din),
      .y    (y_q[i]),
      .full (full_q[i])
    );
  end

  assign y0      = y_q[0];
  assign y1      = y_q[1];
  assign y2      = y_q[2];
  assign y3      = y_q[3];
  assign full    = full_q;
  assign ptr     = ptr_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_demux_1x4_buffered.sv
// Directed and randomized checks of demux_1x4_buffered against a
// cycle-level behavioural model of the channel/pointer rules.
module tb_demux_1x4_buffered;

  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic         auto_mode = 1'b0;
  logic         s1 = 1'b0;
  logic         s0 = 1'b0;
  logic [W-1:0] y0, y1, y2, y3;
  logic [3:0]   full;
  logic [3:0]   ack = '0;
  logic         overrun;
  logic [1:0]   ptr;

  int checks   = 0;
  int failures = 0;

  int m_y    [4];
  bit m_full [4];
  int m_ptr;
  bit m_ovr;

  demux_1x4_buffered #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .auto_mode (auto_mode),
    .s1        (s1),
    .s0        (s0),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .full      (full),
    .ack       (ack),
    .overrun   (overrun),
    .ptr       (ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_target();
    return auto_mode ? m_ptr : (int'(s1) * 2 + int'(s0));
  endfunction

  function automatic logic [3:0] m_full_vec();
    return {m_full[3], m_full[2], m_full[1], m_full[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_y[i]    = 0;
      m_full[i] = 1'b0;
    end
    m_ptr = 0;
    m_ovr = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":y0"}, 32'(y0), 32'(m_y[0]));
    chk({tag, ":y1"}, 32'(y1), 32'(m_y[1]));
    chk({tag, ":y2"}, 32'(y2), 32'(m_y[2]));
    chk({tag, ":y3"}, 32'(y3), 32'(m_y[3]));
    chk({tag, ":full"}, 32'(full), 32'(m_full_vec()));
    chk({tag, ":ptr"}, 32'(ptr), 32'(m_ptr));
    chk({tag, ":overrun"}, 32'(overrun), 32'(m_ovr));
  endtask

  // Drives one cycle of inputs, checks din_ready before the edge, then
  // advances the model and checks registered outputs after the edge.
  task automatic step(input string tag, input bit v, input int d, input bit am,
                      input int sel, input logic [3:0] a);
    int  tgt;
    bit  rdy;
    bit  was_full [4];
    @(negedge clk);
    din_valid = v;
    din       = W'(d);
    auto_mode = am;
    {s1, s0}  = 2'(sel);
    ack       = a;
    #1;
    tgt = m_target();
    rdy = !m_full[tgt];
    chk({tag, ":din_ready"}, 32'(din_ready), 32'(rdy));
    @(posedge clk);
    for (int i = 0; i < 4; i++) was_full[i] = m_full[i];
    for (int i = 0; i < 4; i++) if (a[i] && was_full[i]) m_full[i] = 1'b0;
    if (v && rdy) begin
      m_y[tgt]    = d % 8;
      m_full[tgt] = 1'b1;
      if (am) m_ptr = (m_ptr + 1) % 4;
    end
    m_ovr = v && !rdy;
    #1;
    check_outputs(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Round-robin fill of all four channels with wrap of the pointer
    step("rr0", 1, 5, 1, 0, 4'b0000);
    step("rr1", 1, 6, 1, 0, 4'b0000);
    step("rr2", 1, 7, 1, 0, 4'b0000);
    step("rr3", 1, 1, 1, 0, 4'b0000);
    chk("rr:y_all", {20'd0, 3'(y3), 3'(y2), 3'(y1), 3'(y0)}, {20'd0, 3'd1, 3'd7, 3'd6, 3'd5});
    chk("rr:full", 32'(full), 32'hF);
    chk("rr:ptr_wrap", 32'(ptr), 32'd0);

    // Overrun with all channels full
    step("ovr", 1, 4, 1, 0, 4'b0000);
    chk("ovr:pulse", 32'(overrun), 32'd1);
    chk("ovr:y0_kept", 32'(y0), 32'd5);
    step("ovr_end", 0, 0, 1, 0, 4'b0000);
    chk("ovr:one_cycle", 32'(overrun), 32'd0);

    // Explicit select to channel 2, then ack leaves data in place
    step("clr_all", 0, 0, 0, 0, 4'b1111);
    step("sel2", 1, 3, 0, 2, 4'b0000);
    chk("sel2:y2", 32'(y2), 32'd3);
    chk("sel2:full", 32'(full), 32'b0100);
    chk("sel2:ptr", 32'(ptr), 32'd0);
    step("ack2", 0, 0, 0, 2, 4'b0100);
    chk("ack2:full", 32'(full), 32'b0000);
    chk("ack2:y2", 32'(y2), 32'd3);

    // Ack and write to the same full channel in one cycle
    step("fill1", 1, 2, 0, 1, 4'b0000);
    step("ackwr1", 1, 6, 0, 1, 4'b0010);
    chk("ackwr1:ovr", 32'(overrun), 32'd1);
    chk("ackwr1:full1", 32'(full[1]), 32'd0);
    chk("ackwr1:y1", 32'(y1), 32'd2);
    step("retry1", 1, 6, 0, 1, 4'b0000);
    chk("retry1:y1", 32'(y1), 32'd6);

    // Asynchronous reset between edges while full = 1010
    step("fill3", 1, 7, 0, 3, 4'b0000);
    chk("pre_rst:full", 32'(full), 32'b1010);
    @(negedge clk);
    din_valid = 1'b0;
    ack       = '0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    #1 rst = 1'b0;
    step("post_rst", 1, 4, 1, 0, 4'b0000);
    chk("post_rst:y0", 32'(y0), 32'd4);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           4'($urandom_range(0, 15) & $urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/demux_1x4_buffered.md
DEMUX_1X4_BUFFERED -- requirements
Module: demux_1x4_buffered

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the data word width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port din, input, WIDTH, the data word to distribute.
REQ-005 The block SHALL have port din_valid, input, 1, meaning din holds a word this cycle.
REQ-006 The block SHALL have port din_ready, output, 1, meaning the currently targeted channel can accept a word.
REQ-007 The block SHALL have port auto_mode, input, 1: 0 selects the explicit channel select; 1 selects the internal round-robin pointer.
REQ-008 The block SHALL have ports s1 and s0, input, 1 each, the explicit channel select {s1,s0} used when auto_mode=0.
REQ-009 The block SHALL have ports y0, y1, y2, y3, output, WIDTH each, the per-channel holding registers.
REQ-010 The block SHALL have port full, output, 4, where full[i] set means channel i holds an unconsumed word.
REQ-011 The block SHALL have port ack, input, 4, where ack[i] means the consumer takes channel i.
REQ-012 The block SHALL have port overrun, output, 1, a one-cycle pulse flagging a dropped word.
REQ-013 The block SHALL have port ptr, output, 2, the current round-robin pointer value.

Function
REQ-014 The block SHALL use target = {s1,s0} when auto_mode=0 and target = ptr when auto_mode=1.
REQ-015 The block SHALL drive din_ready combinationally as ~full[target], independent of ack and din_valid.
REQ-016 The block SHALL accept a word (accept = din_valid & din_ready) by loading din into y[target] and setting full[target], both visible one cycle later.
REQ-017 On accept in auto_mode=1, the block SHALL advance ptr by 1 modulo 4 (3 wraps to 0); ptr SHALL hold otherwise, including while auto_mode=0.
REQ-018 On din_valid & ~din_ready, the block SHALL drop the word, pulse overrun high for the next cycle only, and leave y, full and ptr unchanged.
REQ-019 On ack[i], the block SHALL clear full[i] the next cycle; ack[i] on an empty channel SHALL have no effect.
REQ-020 Channel i SHALL accept no word in a cycle where full[i]=1 and ack[i]=1 in the same cycle; full[i] clears and channel i accepts from the following cycle.
REQ-021 The block SHALL hold y[i] until the next accept to channel i; ack SHALL NOT clear y[i].
REQ-022 The block SHALL allow acks on several channels in the same cycle, each acting independently alongside an accept to a different channel.
REQ-023 The block SHALL apply a change of auto_mode, s1 or s0 from the very next cycle's target, with no flush and no pointer reset.

Reset
REQ-024 On assertion of rst, the block SHALL immediately clear y0..y3 to 0, full to 4'b0000, ptr to 0 and overrun to 0, without waiting for clk.
REQ-025 On assertion of rst mid-transfer, the block SHALL discard any in-flight word; the first accept after deassertion goes to channel 0 in auto_mode.

Structure
REQ-026 The block SHALL take from shared package demux_pkg the constants DEFAULT_WIDTH=3 and NUM_CH=4 and a 2-bit channel-index typedef ch_idx_t.
REQ-027 The block SHALL instantiate sub-module demux_channel (holding register plus full flag, with load/ack inputs) once per channel; selection, pointer and overrun logic SHALL stay in the top level.

Verification
REQ-028 The bench SHALL check: rst, then auto_mode=1 with din 5,6,7,1 on valid in 4 consecutive cycles -> y0..y3=5,6,7,1, full=1111, ptr=0 after the wrap.
REQ-029 The bench SHALL check: with all channels full, din=4 valid and auto_mode=1 -> din_ready=0, overrun pulses exactly one cycle, y unchanged, ptr=0.
REQ-030 The bench SHALL check: auto_mode=0, {s1,s0}=2, din=3 valid -> y2=3, full=0100, ptr unchanged; then ack=0100 -> full=0000 while y2 stays 3.
REQ-031 The bench SHALL check: with full[1]=1, apply ack[1] and din=6 valid targeting channel 1 in the same cycle -> word dropped with overrun, full[1]=0 next cycle; retry the next cycle -> y1=6.
REQ-032 The bench SHALL check: rst asserted asynchronously between clock edges while full=1010 -> all outputs are 0 before the next edge; after release, the first auto-mode accept lands in y0.
